// File: rtl/serial_mux_logic_unit.sv
// Bit-serial logic unit: captures two operands, streams them LSB first through a
// 2:1-mux-only gate cell, and returns the reassembled result over valid/ready.
module serial_mux_logic_unit #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic               cell_bit;
    logic [WIDTH-1:0]   result_nxt;

    function automatic logic mux2(input logic sel, input logic d1, input logic d0);
        return sel ? d1 : d0;
    endfunction

    // Every gate is built from mux2 alone; inversion is itself a mux on the input.
    function automatic logic gate_cell(input logic [2:0] opc, input logic x, input logic y);
        logic nx, and_o, or_o;
        nx    = mux2(x, 1'b0, 1'b1);
        and_o = mux2(y, x, 1'b0);
        or_o  = mux2(x, 1'b1, y);
        case (opc)
            3'd0:    return and_o;
            3'd1:    return or_o;
            3'd2:    return nx;
            3'd3:    return mux2(and_o, 1'b0, 1'b1);
            3'd4:    return mux2(or_o, 1'b0, 1'b1);
            3'd5:    return mux2(y, nx, x);
            3'd6:    return mux2(y, x, nx);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        cell_bit              = gate_cell(op_q, a_sh[0], b_sh[0]);
        result_nxt            = result >> 1;
        result_nxt[WIDTH-1]   = cell_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture in IDLE, shift in SHIFT, hold everything in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            op_q   <= 3'd0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        op_q <= op;
                        cnt  <= '0;
                        err  <= (op == 3'd7);
                    end
                end
                S_SHIFT: begin
                    result <= result_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mux_logic_unit.sv
// Directed bench for serial_mux_logic_unit: vector table plus backpressure and
// mid-operation reset sequences.
module tb_serial_mux_logic_unit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             err;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    serial_mux_logic_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepts an op, checks latency and result, leaves the DUT in DONE with out_ready=0.
    task automatic start_and_wait(input string name, input logic [2:0] o,
                                  input logic [7:0] va, input logic [7:0] vb,
                                  input logic [7:0] exp, input logic exp_err);
        int edges;
        chk({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~va;
        b = ~vb;
        op = 3'd7 - o;
        edges = 0;
        while (!out_valid && edges < 20) begin
            chk({name, " in_ready during shift"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, " latency"}, 32'(edges), 32'(WIDTH));
        chk({name, " result"}, 32'(result), 32'(exp));
        chk({name, " err"}, 32'(err), 32'(exp_err));
        chk({name, " busy in done"}, 32'(busy), 32'd1);
    endtask

    task automatic handshake(input string name, input logic [7:0] exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " out_valid after hs"}, 32'(out_valid), 32'd0);
        chk({name, " in_ready after hs"}, 32'(in_ready), 32'd1);
        chk({name, " result held after hs"}, 32'(result), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{"AND",  3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{"XOR",  3'd5, 8'hA5, 8'hFF, 8'h5A, 1'b0};
        vecs[2] = '{"XNOR", 3'd6, 8'hA5, 8'hFF, 8'hA5, 1'b0};
        vecs[3] = '{"NOR",  3'd4, 8'h0F, 8'h30, 8'hC0, 1'b0};
        vecs[4] = '{"NOT",  3'd2, 8'h0F, 8'hAA, 8'hF0, 1'b0};
        vecs[5] = '{"NAND", 3'd3, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[6] = '{"OR",   3'd1, 8'h01, 8'h80, 8'h81, 1'b0};
        vecs[7] = '{"ILL",  3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};
        vecs[8] = '{"NAND2",3'd3, 8'hC3, 8'h5A, 8'hBD, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            start_and_wait(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                           vecs[i].exp, vecs[i].exp_err);
            handshake(vecs[i].name, vecs[i].exp);
        end

        // Backpressure: DONE held for 5 cycles while inputs toggle.
        start_and_wait("BP", 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = 8'(k * 37);
            b = ~a;
            op = 3'(k);
            @(posedge clk);
            #1;
            chk("BP out_valid held", 32'(out_valid), 32'd1);
            chk("BP result held", 32'(result), 32'h30);
            chk("BP in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake("BP", 8'h30);

        // Async reset after three shift edges discards the op immediately.
        in_valid = 1'b1;
        op = 3'd1;
        a = 8'hFF;
        b = 8'h00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("RST busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("RST out_valid", 32'(out_valid), 32'd0);
        chk("RST result", 32'(result), 32'd0);
        chk("RST busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("RST in_ready after", 32'(in_ready), 32'd1);
        chk("RST out_valid after", 32'(out_valid), 32'd0);
        start_and_wait("POSTRST", 3'd5, 8'h3C, 8'h0F, 8'h33, 1'b0);
        handshake("POSTRST", 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
